// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, ALU control codes,
// the opcode-to-control mapping and the sequencer state type.
package alu_pkg;

  localparam int DATA_W = 5;
  localparam int CTRL_W = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [CTRL_W-1:0] CTRL_AND = 4'd0;
  localparam logic [CTRL_W-1:0] CTRL_OR  = 4'd1;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 4'd2;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPT,
    ST_RESP
  } state_t;

  function automatic logic [CTRL_W-1:0] op_to_ctrl(input logic [1:0] op);
    logic [CTRL_W-1:0] ctrl;
    case (op)
      OP_AND:  ctrl = CTRL_AND;
      OP_OR:   ctrl = CTRL_OR;
      OP_ADD:  ctrl = CTRL_ADD;
      default: ctrl = CTRL_SUB;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. ptr holds the index of the last grant and
// moves only when the caller reports an accept through update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_reg;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the requester that did not win last time goes first.
      2'b11:   grant = ptr_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= 1'b1;
    end else if (update) begin
      ptr_reg <= grant[1];
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto the shared registered ALU and returns each
// result over a response handshake; one operation in flight at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CTRL_W = alu_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_op0,
  input  logic [1:0]        req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] alu_a_reg, alu_b_reg, rsp_data_reg;
  logic [CTRL_W-1:0] alu_ctrl_reg;
  logic [1:0]        rsp_valid_reg;
  logic [1:0]        grant;
  logic              ptr;
  logic              accept;
  logic [DATA_W-1:0] a_next, b_next;
  logic [CTRL_W-1:0] ctrl_next;

  // After an accept the arbiter pointer equals the granted index, so it
  // doubles as the owner of the in-flight transaction.
  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .update (accept),
    .grant  (grant),
    .ptr    (ptr)
  );

  assign accept = (state_reg == ST_IDLE) && (grant != 2'b00);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == ST_IDLE) & grant[gi];
    end
  endgenerate

  always_comb begin
    a_next    = grant[1] ? req_a1 : req_a0;
    b_next    = grant[1] ? req_b1 : req_b0;
    ctrl_next = CTRL_W'(op_to_ctrl(grant[1] ? req_op1 : req_op0));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_CAPT;
      ST_CAPT:  state_next = ST_RESP;
      ST_RESP:  if (rsp_ready[ptr]) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_ctrl_reg  <= '0;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_a_reg    <= a_next;
        alu_b_reg    <= b_next;
        alu_ctrl_reg <= ctrl_next;
      end
      if (state_reg == ST_CAPT) begin
        rsp_data_reg  <= alu_result;
        rsp_valid_reg <= ptr ? 2'b10 : 2'b01;
      end
      if (state_reg == ST_RESP && rsp_ready[ptr]) begin
        rsp_valid_reg <= 2'b00;
      end
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_ctrl  = alu_ctrl_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_valid = rsp_valid_reg;

endmodule
